// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - WB-stage exception/interrupt/eret sequencer driving CP0 strobes and fetch redirect
module exc_ctrl #(
  parameter logic [31:0] EXC_VEC    = 32'hBFC00380,
  parameter logic [4:0]  INT_EXCODE = 5'h00,
  parameter logic [4:0]  ADEL_CODE  = 5'h04,
  parameter logic [4:0]  ADES_CODE  = 5'h05
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic        wb_inst_adel,
  input  logic        wb_ri,
  input  logic        wb_ov,
  input  logic        wb_sys,
  input  logic        wb_bp,
  input  logic        wb_mem_adel,
  input  logic        wb_mem_ades,
  input  logic        wb_eret,
  input  logic [31:0] wb_vaddr,
  input  logic        has_int,
  input  logic [31:0] cp0_epc,
  output logic        cp0_exc,
  output logic        cp0_eret,
  output logic [4:0]  cp0_excode,
  output logic        cp0_bd,
  output logic [31:0] cp0_pc,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_inst_adel,
  output logic        cp0_mem_adel,
  output logic        cp0_mem_ades,
  output logic        wb_commit,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic [0:0] {IDLE, REDIRECT} state_t;

  state_t      state_q, state_d;
  logic        int_pend_q, int_pend_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        take_int;
  logic        is_exc;
  logic [4:0]  code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      int_pend_q    <= 1'b0;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      int_pend_q    <= int_pend_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    redirect_pc_d  = redirect_pc_q;
    cp0_exc        = 1'b0;
    cp0_eret       = 1'b0;
    cp0_excode     = 5'h0;
    cp0_bd         = 1'b0;
    cp0_pc         = 32'h0;
    cp0_badvaddr   = 32'h0;
    cp0_inst_adel  = 1'b0;
    cp0_mem_adel   = 1'b0;
    cp0_mem_ades   = 1'b0;
    wb_commit      = 1'b0;
    flush          = 1'b0;
    is_exc         = 1'b1;
    code           = 5'h0;
    take_int       = (state_q == IDLE) && wb_valid && int_pend_q;
    int_pend_d     = has_int & ~take_int;
    redirect_valid = (state_q == REDIRECT);
    redirect_pc    = redirect_pc_q;

    // Single priority chain: at most one event wins per cycle.
    if      (take_int)     code = INT_EXCODE;
    else if (wb_inst_adel) code = ADEL_CODE;
    else if (wb_ri)        code = 5'h0a;
    else if (wb_ov)        code = 5'h0c;
    else if (wb_sys)       code = 5'h08;
    else if (wb_bp)        code = 5'h09;
    else if (wb_mem_adel)  code = ADEL_CODE;
    else if (wb_mem_ades)  code = ADES_CODE;
    else                   is_exc = 1'b0;

    case (state_q)
      IDLE: begin
        if (wb_valid && is_exc) begin
          cp0_exc       = 1'b1;
          cp0_excode    = code;
          cp0_bd        = wb_bd;
          cp0_pc        = wb_pc;
          flush         = 1'b1;
          cp0_inst_adel = !take_int && wb_inst_adel;
          cp0_mem_adel  = !take_int && !wb_inst_adel && !wb_ri && !wb_ov && !wb_sys && !wb_bp
                          && wb_mem_adel;
          cp0_mem_ades  = !take_int && !wb_inst_adel && !wb_ri && !wb_ov && !wb_sys && !wb_bp
                          && !wb_mem_adel && wb_mem_ades;
          if (cp0_mem_adel || cp0_mem_ades) cp0_badvaddr = wb_vaddr;
          else if (cp0_inst_adel)           cp0_badvaddr = wb_pc;
          state_d       = REDIRECT;
          redirect_pc_d = EXC_VEC;
        end else if (wb_valid && wb_eret) begin
          cp0_eret      = 1'b1;
          flush         = 1'b1;
          state_d       = REDIRECT;
          redirect_pc_d = cp0_epc;
        end else begin
          wb_commit = wb_valid;
        end
      end
      REDIRECT: begin
        flush = 1'b1;
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Combinational outputs are forced quiet while reset is held.
    if (!reset) begin
      cp0_exc       = 1'b0;
      cp0_eret      = 1'b0;
      cp0_excode    = 5'h0;
      cp0_bd        = 1'b0;
      cp0_pc        = 32'h0;
      cp0_badvaddr  = 32'h0;
      cp0_inst_adel = 1'b0;
      cp0_mem_adel  = 1'b0;
      cp0_mem_ades  = 1'b0;
      wb_commit     = 1'b0;
      flush         = 1'b0;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - scoreboard bench for exc_ctrl
module tb_exc_ctrl;

  typedef struct packed {
    logic        exc;
    logic        eret;
    logic [4:0]  excode;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] badv;
    logic        ia;
    logic        ma;
    logic        ms;
    logic        commit;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0, wb_bd = 1'b0, wb_inst_adel = 1'b0, wb_ri = 1'b0, wb_ov = 1'b0;
  logic        wb_sys = 1'b0, wb_bp = 1'b0, wb_mem_adel = 1'b0, wb_mem_ades = 1'b0, wb_eret = 1'b0;
  logic        has_int = 1'b0, redirect_ready = 1'b0;
  logic [31:0] wb_pc = 32'h0, wb_vaddr = 32'h0, cp0_epc = 32'h0;
  logic        cp0_exc, cp0_eret, cp0_bd, cp0_inst_adel, cp0_mem_adel, cp0_mem_ades;
  logic        wb_commit, flush, redirect_valid;
  logic [4:0]  cp0_excode;
  logic [31:0] cp0_pc, cp0_badvaddr, redirect_pc;

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t sb_q[$];
  string tag_q[$];
  out_t got, e;

  localparam logic [31:0] VEC = 32'hBFC00380;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_bd(wb_bd),
    .wb_inst_adel(wb_inst_adel), .wb_ri(wb_ri), .wb_ov(wb_ov), .wb_sys(wb_sys), .wb_bp(wb_bp),
    .wb_mem_adel(wb_mem_adel), .wb_mem_ades(wb_mem_ades), .wb_eret(wb_eret), .wb_vaddr(wb_vaddr),
    .has_int(has_int), .cp0_epc(cp0_epc), .cp0_exc(cp0_exc), .cp0_eret(cp0_eret),
    .cp0_excode(cp0_excode), .cp0_bd(cp0_bd), .cp0_pc(cp0_pc), .cp0_badvaddr(cp0_badvaddr),
    .cp0_inst_adel(cp0_inst_adel), .cp0_mem_adel(cp0_mem_adel), .cp0_mem_ades(cp0_mem_ades),
    .wb_commit(wb_commit), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  assign got = '{exc: cp0_exc, eret: cp0_eret, excode: cp0_excode, bd: cp0_bd, pc: cp0_pc,
                 badv: cp0_badvaddr, ia: cp0_inst_adel, ma: cp0_mem_adel, ms: cp0_mem_ades,
                 commit: wb_commit, flush: flush, rv: redirect_valid, rpc: redirect_pc};

  task automatic clear_wb();
    wb_valid = 0; wb_bd = 0; wb_inst_adel = 0; wb_ri = 0; wb_ov = 0; wb_sys = 0;
    wb_bp = 0; wb_mem_adel = 0; wb_mem_ades = 0; wb_eret = 0;
  endtask

  function automatic out_t exc_exp(logic [4:0] code, logic bd, logic [31:0] pc,
                                   logic [31:0] badv, logic [31:0] rpc);
    out_t o = '0;
    o.exc = 1; o.excode = code; o.bd = bd; o.pc = pc; o.badv = badv; o.flush = 1; o.rpc = rpc;
    return o;
  endfunction

  function automatic out_t redir_exp(logic [31:0] rpc);
    out_t o = '0;
    o.flush = 1; o.rv = 1; o.rpc = rpc;
    return o;
  endfunction

  function automatic out_t idle_exp(logic commit, logic [31:0] rpc);
    out_t o = '0;
    o.commit = commit; o.rpc = rpc;
    return o;
  endfunction

  // Push expectation, compare at the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input out_t exp);
    out_t  x;
    string t;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    x = sb_q.pop_front();
    t = tag_q.pop_front();
    n_tests++;
    assert (got === x) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", t, got, x);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    wb_valid = 1; wb_ov = 1; wb_pc = 32'h100;
    step("reset_quiet0", '0);
    step("reset_quiet1", '0);
    reset = 1;
    step("ov_after_reset", exc_exp(5'h0c, 0, 32'h100, 0, 0));
    clear_wb(); redirect_ready = 1;
    step("ov_redirect", redir_exp(VEC));
    wb_valid = 1; wb_pc = 32'h200;
    step("plain_commit", idle_exp(1, VEC));

    clear_wb(); redirect_ready = 0;
    wb_valid = 1; wb_pc = 32'h1000; wb_bd = 1; wb_ri = 1;
    step("ri_bd", exc_exp(5'h0a, 1, 32'h1000, 0, VEC));
    for (int i = 0; i < 3; i++) step("ri_hold", redir_exp(VEC));
    redirect_ready = 1;
    step("ri_accept", redir_exp(VEC));
    clear_wb();
    step("ri_idle", idle_exp(0, VEC));

    wb_valid = 1; wb_pc = 32'hBFC00001; wb_inst_adel = 1; wb_mem_ades = 1; wb_vaddr = 32'h12345678;
    e = exc_exp(5'h04, 0, 32'hBFC00001, 32'hBFC00001, VEC); e.ia = 1;
    step("inst_adel_wins", e);
    clear_wb();
    step("inst_adel_redir", redir_exp(VEC));

    wb_valid = 1; wb_pc = 32'h2000; wb_mem_ades = 1; wb_vaddr = 32'h80000003;
    e = exc_exp(5'h05, 0, 32'h2000, 32'h80000003, VEC); e.ms = 1;
    step("mem_ades", e);
    clear_wb();
    step("mem_ades_redir", redir_exp(VEC));

    wb_valid = 1; wb_pc = 32'h2004; wb_mem_adel = 1; wb_vaddr = 32'h00000011;
    e = exc_exp(5'h04, 0, 32'h2004, 32'h11, VEC); e.ma = 1;
    step("mem_adel", e);
    clear_wb();
    step("mem_adel_redir", redir_exp(VEC));

    wb_valid = 1; wb_pc = 32'h2008; wb_ov = 1; wb_mem_adel = 1;
    step("ov_over_mem_adel", exc_exp(5'h0c, 0, 32'h2008, 0, VEC));
    clear_wb();
    step("ov_redir", redir_exp(VEC));

    wb_valid = 1; wb_pc = 32'h200c; wb_sys = 1; wb_bp = 1;
    step("sys_over_bp", exc_exp(5'h08, 0, 32'h200c, 0, VEC));
    clear_wb();
    step("sys_redir", redir_exp(VEC));

    has_int = 1;
    step("int_arm", idle_exp(0, VEC));
    has_int = 0; wb_valid = 1; wb_pc = 32'h3000; wb_sys = 1;
    step("int_wins", exc_exp(5'h00, 0, 32'h3000, 0, VEC));
    clear_wb();
    step("int_redir", redir_exp(VEC));

    wb_valid = 1; wb_pc = 32'h3004; wb_eret = 1; cp0_epc = 32'hBFC01234; redirect_ready = 0;
    e = '0; e.eret = 1; e.flush = 1; e.rpc = VEC;
    step("eret", e);
    cp0_epc = 32'hDEAD0000;
    step("eret_in_redirect", redir_exp(32'hBFC01234));
    redirect_ready = 1;
    step("eret_accept", redir_exp(32'hBFC01234));
    clear_wb();
    step("eret_idle", idle_exp(0, 32'hBFC01234));

    has_int = 1;
    step("int_drop0", idle_exp(0, 32'hBFC01234));
    has_int = 0;
    step("int_drop1", idle_exp(0, 32'hBFC01234));
    wb_valid = 1; wb_pc = 32'h4000;
    step("int_dropped_commit", idle_exp(1, 32'hBFC01234));

    wb_bp = 1; redirect_ready = 0;
    step("bp", exc_exp(5'h09, 0, 32'h4000, 0, 32'hBFC01234));
    step("bp_redir", redir_exp(VEC));
    reset = 0;
    step("reset_mid_redirect", '0);
    reset = 1; clear_wb();
    step("after_reset_idle", '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
